jk_cmd_sequencer: RTL

JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

---
 rtl/jk_cmd_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/jk_cmd_sequencer.sv
// Command FIFO feeding a three-state pulse sequencer that drives a level-sensitive JK latch.
// Optional predicted-latch shadow register and q_pred port: define JK_CMD_SHADOW_EN.
module jk_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int PULSE_W = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       J,
    output logic       K,
    output logic       en,
    output logic       busy,
    output logic [4:0] level
`ifdef JK_CMD_SHADOW_EN
    ,
    output logic       q_pred
`endif
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_L = 5'(DEPTH);
    localparam logic [2:0] PW_LAST = 3'(PULSE_W - 1);
    localparam logic [1:0] OP_TOG  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_GAP   = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      mem_q [DEPTH];
    logic [1:0]      mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [4:0]      level_q, level_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            j_q, j_d, k_q, k_d, en_q, en_d;
    logic            push_s, pop_s, drive_done_s;
    logic [1:0]      head_op_s;

    assign cmd_ready = (level_q < DEPTH_L);
    assign push_s    = cmd_valid & cmd_ready;
    assign head_op_s = mem_q[rd_ptr_q];
    assign J         = j_q;
    assign K         = k_q;
    assign en        = en_q;
    assign level     = level_q;
    assign busy      = (state_q != ST_IDLE) || (level_q != 5'd0);

    // FIFO storage, pointers and occupancy; push and pop may coincide
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = cmd_op;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        level_d = level_q + {4'b0000, push_s} - {4'b0000, pop_s};
    end

    // Sequencer next state; J = op[1], K = op[0] for every op, so decode is a plain copy
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        j_d          = j_q;
        k_d          = k_q;
        en_d         = en_q;
        pop_s        = 1'b0;
        drive_done_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (level_q != 5'd0) begin
                    pop_s   = 1'b1;
                    state_d = ST_DRIVE;
                    j_d     = head_op_s[1];
                    k_d     = head_op_s[0];
                    en_d    = 1'b1;
                    // a toggle held longer than one cycle would keep flipping the latch
                    cnt_d   = (head_op_s == OP_TOG) ? 3'd0 : PW_LAST;
                end else begin
                    j_d  = 1'b0;
                    k_d  = 1'b0;
                    en_d = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == 3'd0) begin
                    drive_done_s = 1'b1;
                    state_d      = ST_GAP;
                    j_d          = 1'b0;
                    k_d          = 1'b0;
                    en_d         = 1'b0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
                j_d     = 1'b0;
                k_d     = 1'b0;
                en_d    = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                j_d     = 1'b0;
                k_d     = 1'b0;
                en_d    = 1'b0;
            end
        endcase
    end

    // State, FIFO and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mem_q    <= '{default: 2'b00};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= 5'd0;
            cnt_q    <= 3'd0;
            j_q      <= 1'b0;
            k_q      <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            j_q      <= j_d;
            k_q      <= k_d;
            en_q     <= en_d;
        end
    end

`ifdef JK_CMD_SHADOW_EN
    logic qp_q, qp_d;

    assign q_pred = qp_q;

    function automatic logic next_qpred(input logic [1:0] op, input logic q);
        case (op)
            2'b01:   next_qpred = 1'b0;
            2'b10:   next_qpred = 1'b1;
            2'b11:   next_qpred = ~q;
            default: next_qpred = q;
        endcase
    endfunction

    // Shadow model of the latch, advanced once per command as its drive ends
    always_comb begin
        qp_d = qp_q;
        if (drive_done_s) begin
            qp_d = next_qpred({j_q, k_q}, qp_q);
        end else begin
            qp_d = qp_q;
        end
    end

    // Shadow register
    always_ff @(posedge clk) begin
        if (rst) begin
            qp_q <= 1'b0;
        end else begin
            qp_q <= qp_d;
        end
    end
`endif

endmodule
